// File: rtl/trig_enc_pkg.sv
// Shared types and helpers for the beam trigger encoder.
// Optional feature macro used by the top: TRIG_DROP_COUNT_EN (saturating drop counter).
package trig_enc_pkg;

  // Capture FSM states
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } trig_state_t;

  // Saturation value of the dropped-capture counter
  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  // Width of one trigger record: {timestamp, beam bits}
  function automatic int rec_width(input int ts_bits, input int nbeams);
    return ts_bits + nbeams;
  endfunction

endpackage

// File: rtl/trig_enc_fifo.sv
// Synchronous first-word-fall-through FIFO for trigger records.
// Head entry is presented combinationally whenever count is non-zero.
module trig_enc_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Fullness is judged on the pre-pop count, so a same-cycle pop never frees room
  assign push_ok = push && (count < FULL_CNT);
  assign pop_ok  = pop && (count != '0);
  assign valid   = (count != '0);
  assign dout    = mem[rd_ptr];

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trig_beam_encoder.sv
// Beam trigger encoder: timestamps qualified beam triggers, applies a
// programmable dead-time after each capture and queues {ts, beams} records.
// Macro TRIG_DROP_COUNT_EN enables the saturating dropped-capture counter;
// without it drop_count_o is tied to zero.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_IDLE    | armed, capture on any qualified beam when enabled
// ST_HOLDOFF | dead-time, triggers ignored until counter hits 1
module trig_beam_encoder
  import trig_enc_pkg::*;
#(
  parameter int NBEAMS     = 2,
  parameter int TS_BITS    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                  ifclk_i,
  input  logic                                  rst_i,
  input  logic [NBEAMS-1:0]                     trig_i,
  input  logic [NBEAMS-1:0]                     mask_i,
  input  logic                                  enable_i,
  input  logic [7:0]                            holdoff_i,
  output logic [rec_width(TS_BITS, NBEAMS)-1:0] trig_dat_o,
  output logic                                  trig_valid_o,
  input  logic                                  trig_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]           fifo_count_o,
  output logic                                  overflow_o,
  output logic [15:0]                           drop_count_o
);

  localparam int REC_W = rec_width(TS_BITS, NBEAMS);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [TS_BITS-1:0] ts;
  logic [TS_BITS-1:0] ts_s;
  logic [NBEAMS-1:0]  q_s;
  trig_state_t        state;
  logic [7:0]         hold_cnt;
  logic               capture;
  logic               full;
  logic               push;
  logic               pop;

  // Free-running timestamp
  always_ff @(posedge ifclk_i) begin
    if (rst_i) ts <= '0;
    else       ts <= ts + 1'b1;
  end

  // Sample qualified beams together with the timestamp of the same cycle
  always_ff @(posedge ifclk_i) begin
    if (rst_i) begin
      q_s  <= '0;
      ts_s <= '0;
    end else begin
      q_s  <= trig_i & ~mask_i;
      ts_s <= ts;
    end
  end

  assign capture = (state == ST_IDLE) && enable_i && (q_s != '0);
  assign full    = (fifo_count_o == FULL_CNT);
  assign push    = capture && !full;
  assign pop     = trig_valid_o && trig_ready_i;

  // Capture FSM with holdoff counter and sticky overflow flag
  always_ff @(posedge ifclk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (capture && full) overflow_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (capture && (holdoff_i != 8'd0)) begin
            hold_cnt <= holdoff_i;
            state    <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt <= 8'd1) begin
            hold_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TRIG_DROP_COUNT_EN
  logic [15:0] drop_cnt;

  // Count captures lost to a full FIFO, holding at the maximum
  always_ff @(posedge ifclk_i) begin
    if (rst_i) begin
      drop_cnt <= '0;
    end else if (capture && full && (drop_cnt != DROP_SAT)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_count_o = drop_cnt;
`else
  assign drop_count_o = '0;
`endif

  trig_enc_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ifclk_i),
    .rst   (rst_i),
    .push  (push),
    .din   ({ts_s, q_s}),
    .pop   (pop),
    .dout  (trig_dat_o),
    .valid (trig_valid_o),
    .count (fifo_count_o)
  );

endmodule

// File: tb/tb_trig_beam_encoder.sv
// Self-checking bench for trig_beam_encoder against a queue-based reference model.
module tb_trig_beam_encoder;

  localparam int NB    = 2;
  localparam int TSB   = 16;
  localparam int DEPTH = 16;
  localparam int RW    = TSB + NB;
  localparam int CW    = 5;

  logic          ifclk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [NB-1:0] trig_i = '0;
  logic [NB-1:0] mask_i = '0;
  logic          enable_i = 1'b1;
  logic [7:0]    holdoff_i = '0;
  logic [RW-1:0] trig_dat_o;
  logic          trig_valid_o;
  logic          trig_ready_i = 1'b0;
  logic [CW-1:0] fifo_count_o;
  logic          overflow_o;
  logic [15:0]   drop_count_o;

  trig_beam_encoder #(.NBEAMS(NB), .TS_BITS(TSB), .FIFO_DEPTH(DEPTH)) dut (
    .ifclk_i      (ifclk_i),
    .rst_i        (rst_i),
    .trig_i       (trig_i),
    .mask_i       (mask_i),
    .enable_i     (enable_i),
    .holdoff_i    (holdoff_i),
    .trig_dat_o   (trig_dat_o),
    .trig_valid_o (trig_valid_o),
    .trig_ready_i (trig_ready_i),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .drop_count_o (drop_count_o)
  );

  always #5 ifclk_i = ~ifclk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [RW-1:0] mq[$];
  int            m_ts = 0;
  logic [NB-1:0] p_q = '0;
  int            p_ts = 0;
  longint        cyc = 0;
  longint        dead_until = 0;
  bit            m_ovf = 0;
  int            m_drop = 0;

`ifdef TRIG_DROP_COUNT_EN
  localparam int DROP_ON = 1;
`else
  localparam int DROP_ON = 0;
`endif

  // Advance model by one clock given current inputs, then clock the DUT
  task automatic step();
    int pre;
    if (rst_i) begin
      mq.delete();
      m_ts = 0; p_q = '0; p_ts = 0; dead_until = 0; m_ovf = 0; m_drop = 0;
    end else begin
      pre = mq.size();
      if (pre > 0 && trig_ready_i) void'(mq.pop_front());
      if (cyc >= dead_until && enable_i && p_q != '0) begin
        dead_until = cyc + longint'(holdoff_i) + 1;
        if (pre < DEPTH) mq.push_back({p_ts[TSB-1:0], p_q});
        else begin
          m_ovf = 1;
          if (DROP_ON != 0 && m_drop < 65535) m_drop++;
        end
      end
      p_q  = trig_i & ~mask_i;
      p_ts = m_ts;
      m_ts = (m_ts + 1) % 65536;
    end
    cyc++;
    @(posedge ifclk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) step();
    total++; if (trig_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", trig_valid_o); end
    total++; if (fifo_count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count_o); end
    total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_o); end
    total++; if (drop_count_o !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_count_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_latency();
    int n;
    trig_ready_i = 1'b1; holdoff_i = 8'd0; enable_i = 1'b1; mask_i = '0;
    n = 0;
    while (m_ts != 16'h0010 && n < 100) begin step(); n++; end
    total++; if (m_ts != 16'h0010) begin bad++; $display("FAIL lat_align got=%0d exp=16", m_ts); end
    trig_i = 2'b01; step(); trig_i = 2'b00;
    total++; if (trig_valid_o !== 1'b0) begin bad++; $display("FAIL lat_n1 got=%b exp=0", trig_valid_o); end
    step();
    total++; if (trig_valid_o !== 1'b1) begin bad++; $display("FAIL lat_n2_valid got=%b exp=1", trig_valid_o); end
    total++; if (trig_dat_o !== {16'h0010, 2'b01}) begin bad++; $display("FAIL lat_n2_dat got=%h exp=%h", trig_dat_o, {16'h0010, 2'b01}); end
    step();
    total++; if (trig_valid_o !== 1'b0) begin bad++; $display("FAIL lat_n3 got=%b exp=0", trig_valid_o); end
  endtask

  task automatic test_mask();
    trig_ready_i = 1'b0; holdoff_i = 8'd0;
    trig_i = 2'b11; mask_i = 2'b10; step(); trig_i = 2'b00; mask_i = 2'b00;
    step();
    total++; if (trig_valid_o !== 1'b1 || trig_dat_o[1:0] !== 2'b01) begin bad++; $display("FAIL mask_partial got=%b/%b exp=1/01", trig_valid_o, trig_dat_o[1:0]); end
    total++; if (trig_dat_o !== mq[0]) begin bad++; $display("FAIL mask_dat got=%h exp=%h", trig_dat_o, mq[0]); end
    trig_ready_i = 1'b1; step(); trig_ready_i = 1'b0;
    trig_i = 2'b11; mask_i = 2'b11; step(); trig_i = 2'b00;
    repeat (3) step();
    mask_i = 2'b00;
    total++; if (fifo_count_o !== 5'd0 || trig_valid_o !== 1'b0) begin bad++; $display("FAIL mask_full got=%0d/%b exp=0/0", fifo_count_o, trig_valid_o); end
  endtask

  task automatic test_holdoff();
    logic [RW-1:0] r0, r1, r2;
    rst_i = 1'b1; step(); rst_i = 1'b0;
    trig_ready_i = 1'b0; holdoff_i = 8'd4; trig_i = 2'b11; mask_i = 2'b00;
    repeat (12) step();
    trig_i = 2'b00;
    repeat (3) step();
    total++; if (fifo_count_o !== 5'd3) begin bad++; $display("FAIL hold_count got=%0d exp=3", fifo_count_o); end
    r0 = trig_dat_o; trig_ready_i = 1'b1; step();
    r1 = trig_dat_o; step();
    r2 = trig_dat_o; trig_ready_i = 1'b0;
    total++; if (r1[RW-1:NB] - r0[RW-1:NB] !== 16'd5) begin bad++; $display("FAIL hold_gap1 got=%0d exp=5", r1[RW-1:NB] - r0[RW-1:NB]); end
    total++; if (r2[RW-1:NB] - r1[RW-1:NB] !== 16'd5) begin bad++; $display("FAIL hold_gap2 got=%0d exp=5", r2[RW-1:NB] - r1[RW-1:NB]); end
    total++; if (r0[1:0] !== 2'b11) begin bad++; $display("FAIL hold_beams got=%b exp=11", r0[1:0]); end
    trig_ready_i = 1'b1; step(); trig_ready_i = 1'b0; holdoff_i = 8'd0;
  endtask

  task automatic test_overflow();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    trig_ready_i = 1'b0; holdoff_i = 8'd0; trig_i = 2'b01;
    repeat (20) step();
    trig_i = 2'b00;
    repeat (2) step();
    total++; if (fifo_count_o !== 5'd16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", fifo_count_o); end
    total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow_o); end
    total++; if (drop_count_o !== 16'(DROP_ON * 4)) begin bad++; $display("FAIL ovf_drop got=%0d exp=%0d", drop_count_o, DROP_ON * 4); end
    // pop and capture in the same cycle with a full FIFO
    trig_i = 2'b01; step(); trig_i = 2'b00;
    trig_ready_i = 1'b1; step(); trig_ready_i = 1'b0;
    total++; if (fifo_count_o !== 5'd15) begin bad++; $display("FAIL fullpop_count got=%0d exp=15", fifo_count_o); end
    total++; if (drop_count_o !== 16'(DROP_ON * 5)) begin bad++; $display("FAIL fullpop_drop got=%0d exp=%0d", drop_count_o, DROP_ON * 5); end
    total++; if (trig_dat_o !== mq[0]) begin bad++; $display("FAIL fullpop_dat got=%h exp=%h", trig_dat_o, mq[0]); end
  endtask

  task automatic test_reset_mid();
    rst_i = 1'b1; step(); rst_i = 1'b0;
    trig_ready_i = 1'b0; holdoff_i = 8'd0;
    trig_i = 2'b01; step(); trig_i = 2'b00; step();
    trig_i = 2'b10; step(); trig_i = 2'b00; step();
    holdoff_i = 8'd50;
    trig_i = 2'b11; step(); trig_i = 2'b00; step();
    step();
    total++; if (fifo_count_o !== 5'd3) begin bad++; $display("FAIL mid_pre got=%0d exp=3", fifo_count_o); end
    rst_i = 1'b1; step(); rst_i = 1'b0;
    total++; if (fifo_count_o !== 5'd0 || trig_valid_o !== 1'b0 || overflow_o !== 1'b0) begin bad++; $display("FAIL mid_clear got=%0d/%b/%b exp=0/0/0", fifo_count_o, trig_valid_o, overflow_o); end
    holdoff_i = 8'd0;
    trig_i = 2'b01; step(); trig_i = 2'b00; step();
    total++; if (trig_valid_o !== 1'b1 || trig_dat_o !== {16'h0000, 2'b01}) begin bad++; $display("FAIL mid_ts got=%b/%h exp=1/%h", trig_valid_o, trig_dat_o, {16'h0000, 2'b01}); end
  endtask

  task automatic test_random();
    int errs_before;
    errs_before = bad;
    for (int i = 0; i < 3000; i++) begin
      trig_i       = NB'($urandom);
      mask_i       = ($urandom_range(0, 3) == 0) ? NB'($urandom) : '0;
      enable_i     = ($urandom_range(0, 7) != 0);
      trig_ready_i = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      holdoff_i    = 8'($urandom_range(0, 6));
      rst_i        = ($urandom_range(0, 799) == 0);
      step();
      if (bad - errs_before < 10) begin
        total++; if (trig_valid_o !== (mq.size() > 0)) begin bad++; $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, trig_valid_o, mq.size() > 0); end
        total++; if (fifo_count_o !== CW'(mq.size())) begin bad++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, fifo_count_o, mq.size()); end
        if (mq.size() > 0) begin
          total++; if (trig_dat_o !== mq[0]) begin bad++; $display("FAIL rnd_dat i=%0d got=%h exp=%h", i, trig_dat_o, mq[0]); end
        end
        total++; if (overflow_o !== m_ovf) begin bad++; $display("FAIL rnd_ovf i=%0d got=%b exp=%b", i, overflow_o, m_ovf); end
        total++; if (drop_count_o !== 16'(m_drop)) begin bad++; $display("FAIL rnd_drop i=%0d got=%0d exp=%0d", i, drop_count_o, m_drop); end
      end
    end
    rst_i = 1'b0; enable_i = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_latency();
    test_mask();
    test_holdoff();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
